// File: rtl/id_hazard_ctrl_pkg.sv
// rtl/id_hazard_ctrl_pkg.sv - shared types and constants for the ID hazard controller
// Purpose: FSM state encoding and per-hazard stall lengths.
// Ports: none (package).
package id_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_STALL    = 2'd1,
    HZ_WAIT_MEM = 2'd2
  } hz_state_e;

  // Total stall cycles per hazard class, counting the detecting cycle.
  localparam logic [1:0] STALL_NONE    = 2'd0;
  localparam logic [1:0] STALL_LOADUSE = 2'd1;
  localparam logic [1:0] STALL_BR_ALU  = 2'd1;
  localparam logic [1:0] STALL_BR_LOAD = 2'd2;

endpackage

// File: rtl/id_hazard_ctrl_hazard_match.sv
// rtl/id_hazard_ctrl_hazard_match.sv - register match and hazard classification
// Purpose: compare ID source registers against EX/MEM destinations and return
//          the number of stall cycles the ID instruction needs.
// Ports:
//   id_rs1, id_rs2       : ID source register indices
//   id_branch_or_jalr    : ID instruction resolves its operands in ID
//   ex_rd/ex_regwrite/ex_memread : EX destination and control
//   mem_rd/mem_memread   : MEM destination and load flag
//   ex_hit, mem_ld_hit   : match flags
//   stall_n              : stall cycles required (0 = no hazard)
module hazard_match
  import id_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_branch_or_jalr,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_memread,
  output logic             ex_hit,
  output logic             mem_ld_hit,
  output logic [1:0]       stall_n
);

  logic ex_rd_nz;
  logic mem_rd_nz;

  // x0 is hardwired, so a write to it can never create a dependency.
  assign ex_rd_nz  = (ex_rd != '0);
  assign mem_rd_nz = (mem_rd != '0);

  always_comb begin
    ex_hit     = ex_regwrite & ex_rd_nz & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    mem_ld_hit = mem_memread & mem_rd_nz & ((mem_rd == id_rs1) | (mem_rd == id_rs2));

    // Priority order matters: a branch on a load in EX needs the longer wait.
    stall_n = STALL_NONE;
    if (id_branch_or_jalr & ex_hit & ex_memread) begin
      stall_n = STALL_BR_LOAD;
    end else if (id_branch_or_jalr & (ex_hit | mem_ld_hit)) begin
      stall_n = STALL_BR_ALU;
    end else if (!id_branch_or_jalr & ex_hit & ex_memread) begin
      stall_n = STALL_LOADUSE;
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - ID-stage hazard controller with stall sequencing FSM
// Purpose: detect load-use and branch/jalr operand hazards, sequence multi-cycle
//          stalls, fold in memory (AXI/cache) freezes and produce the PC, IF/ID
//          and bubble enables plus registered flush / re-decode strobes.
// Ports:
//   clk, rst (async active-low)
//   id_*            : ID instruction sources, branch/jump info
//   ex_*, mem_*     : downstream destination / control
//   im_stall, dm_stall : memory waits
//   pc_write, if_id_write, hazard_sel_mux, stall : combinational controls
//   if_id_write_delay, if_flush_out : registered 1-cycle strobes
//   hz_state        : current FSM state
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_branch_or_jalr,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_memread,
  input  logic             im_stall,
  input  logic             dm_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             hazard_sel_mux,
  output logic             if_id_write_delay,
  output logic             if_flush_out,
  output logic             stall,
  output logic [1:0]       hz_state
);

  hz_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       flush_q, flush_d;
  logic       delay_q, delay_d;

  logic       ex_hit;
  logic       mem_ld_hit;
  logic [1:0] stall_n;
  logic       mem_busy;
  logic       hazard;
  logic       redirect;

  hazard_match u_match (
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_branch_or_jalr (id_branch_or_jalr),
    .ex_rd             (ex_rd),
    .ex_regwrite       (ex_regwrite),
    .ex_memread        (ex_memread),
    .mem_rd            (mem_rd),
    .mem_memread       (mem_memread),
    .ex_hit            (ex_hit),
    .mem_ld_hit        (mem_ld_hit),
    .stall_n           (stall_n)
  );

  assign mem_busy = im_stall | dm_stall;
  // A nonzero stall count always comes from a register hit.
  assign hazard   = (stall_n != STALL_NONE) & (ex_hit | mem_ld_hit);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    hazard_sel_mux = 1'b1;
    stall          = 1'b0;
    redirect       = 1'b0;

    if (mem_busy) begin
      // Whole pipeline frozen: no bubble, counter holds, no redirect.
      stall       = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if (state_q == HZ_STALL) begin
        state_d = HZ_WAIT_MEM;
      end
    end else if (rst) begin
      unique case (state_q)
        HZ_RUN: begin
          if (hazard) begin
            // This cycle is the first stall; counter tracks the remainder.
            pc_write       = 1'b0;
            if_id_write    = 1'b0;
            hazard_sel_mux = 1'b0;
            cnt_d          = stall_n - 2'd1;
            state_d        = HZ_STALL;
          end else begin
            redirect = id_branch_taken | id_jump;
          end
        end
        HZ_STALL: begin
          if (cnt_q == 2'd0) begin
            // Release cycle: the held instruction proceeds, so a branch
            // that was waiting on its operands redirects here.
            state_d  = HZ_RUN;
            redirect = id_branch_taken | id_jump;
          end else begin
            pc_write       = 1'b0;
            if_id_write    = 1'b0;
            hazard_sel_mux = 1'b0;
            cnt_d          = cnt_q - 2'd1;
          end
        end
        HZ_WAIT_MEM: begin
          // The freeze swallowed a stall cycle; replay it here, then let
          // STALL finish the sequence with its normal release cycle.
          pc_write       = 1'b0;
          if_id_write    = 1'b0;
          hazard_sel_mux = 1'b0;
          if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
          end
          state_d = HZ_STALL;
        end
        default: begin
          state_d = HZ_RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end

    flush_d = redirect;
    delay_d = ~if_id_write & ~mem_busy;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HZ_RUN;
      cnt_q   <= 2'd0;
      flush_q <= 1'b0;
      delay_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      delay_q <= delay_d;
    end
  end

  assign if_flush_out      = flush_q;
  assign if_id_write_delay = delay_q;
  assign hz_state          = state_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - directed scoreboard bench for id_hazard_ctrl
module tb_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_branch_or_jalr, id_branch_taken, id_jump;
  logic       ex_regwrite, ex_memread, mem_memread, im_stall, dm_stall;
  logic       pc_write, if_id_write, hazard_sel_mux, if_id_write_delay, if_flush_out, stall;
  logic [1:0] hz_state;

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_branch_or_jalr (id_branch_or_jalr),
    .id_branch_taken   (id_branch_taken),
    .id_jump           (id_jump),
    .ex_rd             (ex_rd),
    .ex_regwrite       (ex_regwrite),
    .ex_memread        (ex_memread),
    .mem_rd            (mem_rd),
    .mem_memread       (mem_memread),
    .im_stall          (im_stall),
    .dm_stall          (dm_stall),
    .pc_write          (pc_write),
    .if_id_write       (if_id_write),
    .hazard_sel_mux    (hazard_sel_mux),
    .if_id_write_delay (if_id_write_delay),
    .if_flush_out      (if_flush_out),
    .stall             (stall),
    .hz_state          (hz_state)
  );

  typedef struct packed {
    logic       pw;
    logic       iw;
    logic       hsm;
    logic       st;
    logic [1:0] hs;
    logic       fl;
    logic       dl;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(input logic pw, input logic iw, input logic hsm, input logic st,
                              input logic [1:0] hs, input logic fl, input logic dl);
    exp_t e;
    e.pw = pw; e.iw = iw; e.hsm = hsm; e.st = st; e.hs = hs; e.fl = fl; e.dl = dl;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_branch_or_jalr = 1'b0; id_branch_taken = 1'b0; id_jump = 1'b0;
    ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = 5'd0; mem_memread = 1'b0;
    im_stall = 1'b0; dm_stall = 1'b0;
  endtask

  // Push the expectation for the cycle being driven, compare at the falling
  // edge, then move to just after the next rising edge for the next drive.
  task automatic step(input string name, input exp_t e);
    exp_t g;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s.scoreboard_empty observed=0 expected=1", name);
    end else begin
      g = sb_q.pop_front();
      chk({name, ".pc_write"},          {1'b0, pc_write},          {1'b0, g.pw});
      chk({name, ".if_id_write"},       {1'b0, if_id_write},       {1'b0, g.iw});
      chk({name, ".hazard_sel_mux"},    {1'b0, hazard_sel_mux},    {1'b0, g.hsm});
      chk({name, ".stall"},             {1'b0, stall},             {1'b0, g.st});
      chk({name, ".hz_state"},          hz_state,                  g.hs);
      chk({name, ".if_flush_out"},      {1'b0, if_flush_out},      {1'b0, g.fl});
      chk({name, ".if_id_write_delay"}, {1'b0, if_id_write_delay}, {1'b0, g.dl});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    // Reset state
    step("reset", mk(1, 1, 1, 0, 2'd0, 0, 0));
    rst = 1'b1;
    step("idle", mk(1, 1, 1, 0, 2'd0, 0, 0));

    // Load-use: lw x5 in EX, add with rs1=5 in ID
    ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1; id_rs1 = 5'd5;
    step("lu_detect", mk(0, 0, 0, 0, 2'd0, 0, 0));
    ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; mem_rd = 5'd5; mem_memread = 1'b1;
    step("lu_release", mk(1, 1, 1, 0, 2'd1, 0, 1));
    idle();
    step("lu_run", mk(1, 1, 1, 0, 2'd0, 0, 0));

    // Branch after load, taken: two stalls, flush after release
    ex_rd = 5'd6; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rs2 = 5'd6; id_branch_or_jalr = 1'b1; id_branch_taken = 1'b1;
    step("brld_s1", mk(0, 0, 0, 0, 2'd0, 0, 0));
    ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; mem_rd = 5'd6; mem_memread = 1'b1;
    step("brld_s2", mk(0, 0, 0, 0, 2'd1, 0, 1));
    mem_rd = 5'd0; mem_memread = 1'b0;
    step("brld_rel", mk(1, 1, 1, 0, 2'd1, 0, 1));
    idle();
    step("brld_flush", mk(1, 1, 1, 0, 2'd0, 1, 0));
    step("brld_after", mk(1, 1, 1, 0, 2'd0, 0, 0));

    // Branch after ALU: jalr on rs1=7, one stall then jump flush
    ex_rd = 5'd7; ex_regwrite = 1'b1; id_rs1 = 5'd7;
    id_branch_or_jalr = 1'b1; id_jump = 1'b1;
    step("bralu_s1", mk(0, 0, 0, 0, 2'd0, 0, 0));
    ex_rd = 5'd0; ex_regwrite = 1'b0;
    step("bralu_rel", mk(1, 1, 1, 0, 2'd1, 0, 1));
    idle();
    step("bralu_flush", mk(1, 1, 1, 0, 2'd0, 1, 0));

    // MEM load hit only, branch in ID: one stall
    mem_rd = 5'd9; mem_memread = 1'b1; id_rs2 = 5'd9; id_branch_or_jalr = 1'b1;
    step("memld_s1", mk(0, 0, 0, 0, 2'd0, 0, 0));
    idle();
    step("memld_rel", mk(1, 1, 1, 0, 2'd1, 0, 1));
    step("memld_run", mk(1, 1, 1, 0, 2'd0, 0, 0));

    // Register zero never matches; taken branch redirects from RUN
    ex_rd = 5'd0; ex_regwrite = 1'b1; ex_memread = 1'b1; id_rs1 = 5'd0;
    step("x0_lu", mk(1, 1, 1, 0, 2'd0, 0, 0));
    id_branch_or_jalr = 1'b1; id_branch_taken = 1'b1;
    step("x0_br", mk(1, 1, 1, 0, 2'd0, 0, 0));
    idle();
    step("x0_flush", mk(1, 1, 1, 0, 2'd0, 1, 0));

    // Memory stall in STALL with counter=1
    ex_rd = 5'd6; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rs2 = 5'd6; id_branch_or_jalr = 1'b1;
    step("ms_detect", mk(0, 0, 0, 0, 2'd0, 0, 0));
    dm_stall = 1'b1;
    step("ms_busy1", mk(0, 0, 1, 1, 2'd1, 0, 1));
    step("ms_busy2", mk(0, 0, 1, 1, 2'd2, 0, 0));
    step("ms_busy3", mk(0, 0, 1, 1, 2'd2, 0, 0));
    idle();
    step("ms_replay", mk(0, 0, 0, 0, 2'd2, 0, 0));
    step("ms_rel", mk(1, 1, 1, 0, 2'd1, 0, 1));
    step("ms_run", mk(1, 1, 1, 0, 2'd0, 0, 0));

    // Hazard together with memory wait: freeze wins, hazard re-detected
    ex_rd = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1; id_rs1 = 5'd5; im_stall = 1'b1;
    step("hm_busy", mk(0, 0, 1, 1, 2'd0, 0, 0));
    im_stall = 1'b0;
    step("hm_detect", mk(0, 0, 0, 0, 2'd0, 0, 0));
    idle();
    step("hm_rel", mk(1, 1, 1, 0, 2'd1, 0, 1));
    step("hm_run", mk(1, 1, 1, 0, 2'd0, 0, 0));

    // Reset mid-stall with the hazard still presented
    ex_rd = 5'd6; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rs2 = 5'd6; id_branch_or_jalr = 1'b1;
    step("rs_detect", mk(0, 0, 0, 0, 2'd0, 0, 0));
    step("rs_stall", mk(0, 0, 0, 0, 2'd1, 0, 1));
    rst = 1'b0;
    step("rs_reset", mk(1, 1, 1, 0, 2'd0, 0, 0));
    rst = 1'b1;
    idle();
    step("rs_run", mk(1, 1, 1, 0, 2'd0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
